// File: rtl/alu_reservation_station.sv
// Integer ALU with a private reservation station: buffers issued instructions until
// both operands are captured from the CDB, then runs them through a fixed-latency pipe.
module alu_reservation_station #(
  parameter int WORD_SIZE    = 32,
  parameter int RB_SIZE      = 8,
  parameter int RB_INDEX     = 3,
  parameter int FU_INDEX     = 2,
  parameter int FU_ID        = 0,
  parameter int RS_DEPTH     = 4,
  parameter int EXEC_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [FU_INDEX-1:0]         issue_fu,
  input  logic [WORD_SIZE-1:0]        issue_inst,
  input  logic [RB_INDEX-1:0]         issue_rb,
  input  logic [WORD_SIZE-1:0]        issue_vj,
  input  logic [WORD_SIZE-1:0]        issue_vk,
  input  logic [RB_INDEX-1:0]         issue_qj,
  input  logic [RB_INDEX-1:0]         issue_qk,
  input  logic                        issue_rdy_j,
  input  logic                        issue_rdy_k,
  input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data,
  input  logic [RB_SIZE-1:0]          CDB_data_valid,
  output logic                        busy,
  output logic                        wb_valid,
  output logic [RB_INDEX-1:0]         wb_rb,
  output logic [WORD_SIZE-1:0]        wb_data,
  output logic [WORD_SIZE-1:0]        wb_addr,
  output logic                        overflow
);

  localparam int AGE_W = $clog2(RS_DEPTH) + 1;
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef enum logic [5:0] {
    OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3,
    OP_SLT = 6'd4, OP_ADDI = 6'd5, OP_SW = 6'd7
  } op_e;

  // age = number of valid entries older than this one; 0 is the oldest.
  typedef struct packed {
    logic                 valid;
    logic                 rdy_j;
    logic                 rdy_k;
    logic [WORD_SIZE-1:0] vj;
    logic [WORD_SIZE-1:0] vk;
    logic [RB_INDEX-1:0]  qj;
    logic [RB_INDEX-1:0]  qk;
    logic [RB_INDEX-1:0]  rb;
    logic [5:0]           op;
    logic [15:0]          imm;
    logic [AGE_W-1:0]     age;
  } entry_t;

  entry_t               ent_q [RS_DEPTH];
  entry_t               ent_d [RS_DEPTH];
  logic                 overflow_q, overflow_d;

  logic                 st_valid_q [EXEC_LATENCY];
  logic [RB_INDEX-1:0]  st_rb_q    [EXEC_LATENCY];
  logic [WORD_SIZE-1:0] st_data_q  [EXEC_LATENCY];
  logic [WORD_SIZE-1:0] st_addr_q  [EXEC_LATENCY];

  logic [AGE_W-1:0]     occ;
  logic                 disp_found;
  logic [IDX_W-1:0]     disp_idx;
  logic [AGE_W-1:0]     disp_age;
  entry_t               sel;
  logic [WORD_SIZE-1:0] sel_imm, res_data, res_addr;
  logic                 iss_take, alloc_found;

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    occ        = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    disp_age   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      occ = occ + AGE_W'(ent_q[i].valid);
      if (ent_q[i].valid && ent_q[i].rdy_j && ent_q[i].rdy_k &&
          (!disp_found || ent_q[i].age < disp_age)) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
        disp_age   = ent_q[i].age;
      end
    end
  end

  assign busy = (occ == AGE_W'(RS_DEPTH));

  always_comb begin
    sel      = ent_q[disp_idx];
    sel_imm  = {{(WORD_SIZE-16){sel.imm[15]}}, sel.imm};
    res_data = sel.vj + sel.vk;
    res_addr = '0;
    case (sel.op)
      OP_SUB:  res_data = sel.vj - sel.vk;
      OP_AND:  res_data = sel.vj & sel.vk;
      OP_OR:   res_data = sel.vj | sel.vk;
      OP_SLT:  res_data = {{(WORD_SIZE-1){1'b0}}, ($signed(sel.vj) < $signed(sel.vk))};
      OP_ADDI: res_data = sel.vj + sel_imm;
      OP_SW: begin
        res_data = sel.vk;
        res_addr = sel.vj + sel_imm;
      end
      default: res_data = sel.vj + sel.vk;
    endcase
  end

  always_comb begin
    iss_take    = issue_valid && (issue_fu == FU_INDEX'(FU_ID));
    alloc_found = 1'b0;
    overflow_d  = overflow_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && !ent_q[i].rdy_j && CDB_data_valid[ent_q[i].qj]) begin
        ent_d[i].rdy_j = 1'b1;
        ent_d[i].vj    = CDB_data_data[int'(ent_q[i].qj)*WORD_SIZE +: WORD_SIZE];
      end
      if (ent_q[i].valid && !ent_q[i].rdy_k && CDB_data_valid[ent_q[i].qk]) begin
        ent_d[i].rdy_k = 1'b1;
        ent_d[i].vk    = CDB_data_data[int'(ent_q[i].qk)*WORD_SIZE +: WORD_SIZE];
      end
      if (disp_found && ent_q[i].valid && ent_q[i].age > disp_age)
        ent_d[i].age = ent_q[i].age - 1'b1;
    end
    if (disp_found) ent_d[disp_idx].valid = 1'b0;

    // Allocation looks at post-dispatch occupancy so a freed entry is reusable at once.
    if (iss_take) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (!alloc_found && !ent_d[i].valid) begin
          alloc_found    = 1'b1;
          ent_d[i].valid = 1'b1;
          ent_d[i].rdy_j = issue_rdy_j | CDB_data_valid[issue_qj];
          ent_d[i].rdy_k = issue_rdy_k | CDB_data_valid[issue_qk];
          ent_d[i].vj    = issue_rdy_j ? issue_vj
                                       : CDB_data_data[int'(issue_qj)*WORD_SIZE +: WORD_SIZE];
          ent_d[i].vk    = issue_rdy_k ? issue_vk
                                       : CDB_data_data[int'(issue_qk)*WORD_SIZE +: WORD_SIZE];
          ent_d[i].qj    = issue_qj;
          ent_d[i].qk    = issue_qk;
          ent_d[i].rb    = issue_rb;
          ent_d[i].op    = issue_inst[31:26];
          ent_d[i].imm   = issue_inst[15:0];
          ent_d[i].age   = occ - AGE_W'(disp_found);
        end
      end
      if (!alloc_found) overflow_d = 1'b1;
    end
  end

  // NOTE: entry payloads are reset along with the valid bits; the station is
  // tiny and this keeps every register at a known value after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      overflow_q <= overflow_d;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Result pipe: stage 0 loads at the dispatch edge; idle stages carry zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < EXEC_LATENCY; s++) begin
        st_valid_q[s] <= 1'b0;
        st_rb_q[s]    <= '0;
        st_data_q[s]  <= '0;
        st_addr_q[s]  <= '0;
      end
    end else begin
      st_valid_q[0] <= disp_found;
      st_rb_q[0]    <= disp_found ? sel.rb   : '0;
      st_data_q[0]  <= disp_found ? res_data : '0;
      st_addr_q[0]  <= disp_found ? res_addr : '0;
      for (int s = 1; s < EXEC_LATENCY; s++) begin
        st_valid_q[s] <= st_valid_q[s-1];
        st_rb_q[s]    <= st_rb_q[s-1];
        st_data_q[s]  <= st_data_q[s-1];
        st_addr_q[s]  <= st_addr_q[s-1];
      end
    end
  end

  assign wb_valid = st_valid_q[EXEC_LATENCY-1];
  assign wb_rb    = st_rb_q[EXEC_LATENCY-1];
  assign wb_data  = st_data_q[EXEC_LATENCY-1];
  assign wb_addr  = st_addr_q[EXEC_LATENCY-1];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: directed issues push expected
// write-backs (with their cycle); a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [1:0]  issue_fu;
  logic [31:0] issue_inst;
  logic [2:0]  issue_rb;
  logic [31:0] issue_vj, issue_vk;
  logic [2:0]  issue_qj, issue_qk;
  logic        issue_rdy_j, issue_rdy_k;
  logic [255:0] CDB_data_data;
  logic [7:0]  CDB_data_valid;
  logic        busy, wb_valid, overflow;
  logic [2:0]  wb_rb;
  logic [31:0] wb_data, wb_addr;

  alu_reservation_station dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_inst(issue_inst),
    .issue_rb(issue_rb), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_rdy_j(issue_rdy_j), .issue_rdy_k(issue_rdy_k),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid),
    .busy(busy), .wb_valid(wb_valid), .wb_rb(wb_rb), .wb_data(wb_data),
    .wb_addr(wb_addr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  rb;
    logic [31:0] data;
    logic [31:0] addr;
    int          at;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input logic [2:0] rb, input logic [31:0] d,
                               input logic [31:0] a, input int at);
    exp_t e;
    e.rb = rb; e.data = d; e.addr = a; e.at = at;
    sb.push_back(e);
  endfunction

  // Monitor: each negedge, a wb pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", 96'(wb_valid), 96'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_rb",    96'(wb_rb),   96'(e.rb));
          check("wb_data",  96'(wb_data), 96'(e.data));
          check("wb_addr",  96'(wb_addr), 96'(e.addr));
          check("wb_cycle", 96'(cyc),     96'(e.at));
        end
      end else begin
        check("wb_idle_zero", {29'd0, wb_rb, wb_data, wb_addr}, 96'd0);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  // Called at a negedge; drives one issue for the next posedge, returns that edge number.
  task automatic do_issue(input logic [1:0] fu, input logic [31:0] inst, input logic [2:0] rb,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic [2:0] qj, input logic [2:0] qk,
                          input logic rj, input logic rk, output int e_n);
    issue_valid = 1'b1; issue_fu = fu; issue_inst = inst; issue_rb = rb;
    issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
    issue_rdy_j = rj; issue_rdy_k = rk;
    e_n = cyc + 1;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic cdb_pulse(input int slot, input logic [31:0] d, output int e_n);
    CDB_data_valid[slot] = 1'b1;
    CDB_data_data[slot*32 +: 32] = d;
    e_n = cyc + 1;
    @(negedge clk);
    CDB_data_valid = '0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", 96'(sb.size()), 96'(0));
  endtask

  int e, e1, e2, p;

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_fu = '0; issue_inst = '0; issue_rb = '0;
    issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    issue_rdy_j = 1'b0; issue_rdy_k = 1'b0; CDB_data_data = '0; CDB_data_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy",     96'(busy),     96'(0));
    check("rst_wb_valid", 96'(wb_valid), 96'(0));
    check("rst_wb_rb",    96'(wb_rb),    96'(0));
    check("rst_wb_data",  96'(wb_data),  96'(0));
    check("rst_wb_addr",  96'(wb_addr),  96'(0));
    check("rst_overflow", 96'(overflow), 96'(0));

    // Ready ADD: 5+7 -> 12 two edges after issue.
    do_issue(2'd0, mk(6'd0, 16'h0), 3'd3, 32'd5, 32'd7, 3'd0, 3'd0, 1'b1, 1'b1, e);
    push(3'd3, 32'd12, 32'd0, e + 2);
    drain();

    // Wrong FU: nothing allocated, no wb (monitor flags any).
    do_issue(2'd1, mk(6'd0, 16'h0), 3'd4, 32'd1, 32'd1, 3'd0, 3'd0, 1'b1, 1'b1, e);
    check("wrongfu_busy", 96'(busy), 96'(0));
    repeat (5) @(negedge clk);

    // Operand wait: SUB 10 - slot5, slot5=4 broadcast three edges after issue.
    do_issue(2'd0, mk(6'd1, 16'h0), 3'd2, 32'd10, 32'd0, 3'd0, 3'd5, 1'b1, 1'b0, e);
    repeat (2) @(negedge clk);
    cdb_pulse(5, 32'd4, p);
    check("wait_pulse_edge", 96'(p), 96'(e + 3));
    push(3'd2, 32'd6, 32'd0, p + 2);
    drain();

    // Fill and overflow: four entries wait on slot6, a fifth is dropped.
    for (int i = 0; i < 4; i++)
      do_issue(2'd0, mk(6'd0, 16'h0), 3'(i), 32'd0, 32'(i), 3'd6, 3'd0, 1'b0, 1'b1, e);
    check("fill_busy",       96'(busy),     96'(1));
    check("fill_no_overflow", 96'(overflow), 96'(0));
    do_issue(2'd0, mk(6'd0, 16'h0), 3'd4, 32'd0, 32'd50, 3'd6, 3'd0, 1'b0, 1'b1, e);
    check("overflow_set",    96'(overflow), 96'(1));
    check("overflow_busy",   96'(busy),     96'(1));
    cdb_pulse(6, 32'd100, p);
    for (int i = 0; i < 4; i++) push(3'(i), 32'(100 + i), 32'd0, p + 2 + i);
    drain();
    check("fill_busy_clear", 96'(busy), 96'(0));
    check("overflow_sticky", 96'(overflow), 96'(1));

    // Immediates, SLT and SW issued back-to-back.
    do_issue(2'd0, mk(6'd5, 16'h0002), 3'd1, 32'hFFFF_FFFF, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, e);
    push(3'd1, 32'd1, 32'd0, e + 2);
    do_issue(2'd0, mk(6'd4, 16'h0), 3'd5, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 1'b1, 1'b1, e);
    push(3'd5, 32'd1, 32'd0, e + 2);
    do_issue(2'd0, mk(6'd7, 16'hFFFC), 3'd6, 32'h100, 32'd9, 3'd0, 3'd0, 1'b1, 1'b1, e);
    push(3'd6, 32'd9, 32'hFC, e + 2);
    drain();

    // Async reset while one result is on wb and another is in the pipe.
    do_issue(2'd0, mk(6'd0, 16'h0), 3'd3, 32'd1, 32'd2, 3'd0, 3'd0, 1'b1, 1'b1, e1);
    do_issue(2'd0, mk(6'd0, 16'h0), 3'd4, 32'd3, 32'd4, 3'd0, 3'd0, 1'b1, 1'b1, e2);
    @(posedge clk);
    #1;
    check("prereset_wb_valid", 96'(wb_valid), 96'(1));
    reset = 1'b1;
    #1;
    check("arst_wb_valid", 96'(wb_valid), 96'(0));
    check("arst_wb_rb",    96'(wb_rb),    96'(0));
    check("arst_wb_data",  96'(wb_data),  96'(0));
    check("arst_overflow", 96'(overflow), 96'(0));
    check("arst_busy",     96'(busy),     96'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_reset_sb", 96'(sb.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
